// File: rtl/muldiv_pkg.sv
// Shared encodings and timing constants for the iterative multiply/divide unit.
package muldiv_pkg;

  // Operation select as presented on the op port.
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  // Engine sequencing: accept, WIDTH radix-2 steps, then result write-back.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH  = 32;
  // Edges from the accepting edge to the edge that raises done.
  localparam int unsigned RESULT_LATENCY = DEFAULT_WIDTH + 1;

  // Result latency for an arbitrary operand width.
  function automatic int unsigned latency_of(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
module muldiv_signfix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  // Negating the most negative value yields itself, which reads as 2^(WIDTH-1) unsigned.
  assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with HI/LO result registers and start/busy/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned     CNT_W     = $clog2(WIDTH + 1);
  localparam int unsigned     STEPS     = latency_of(WIDTH) - 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  op_e                op_sel;
  logic               op_signed;
  logic               op_div;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_sel    = op_e'(op);
  assign op_signed = (op_sel == OP_MULT) || (op_sel == OP_DIV);
  assign op_div    = (op_sel == OP_DIVU) || (op_sel == OP_DIV);

  // Operand magnitudes for signed ops.
  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (.neg(op_signed & a[WIDTH-1]), .x(a), .y(abs_a));
  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (.neg(op_signed & b[WIDTH-1]), .x(b), .y(abs_b));

  // Result sign correction applied at write-back.
  muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (.neg(neg_res_q), .x(acc_q), .y(prod_fix));
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (.neg(neg_res_q), .x(acc_q[WIDTH-1:0]), .y(quo_fix));
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (.neg(neg_rem_q), .x(rem_q), .y(rem_fix));

  // Multiply step: add multiplicand into the upper half when the multiplier LSB is set.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvs_q};

  // Restoring divide step; a set shift-out bit guarantees the trial subtract fits.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_sub   = {1'b0, div_shift[WIDTH-1:0]} - {1'b0, dvs_q};
  assign div_ge    = div_shift[WIDTH] | ~div_sub[WIDTH];

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
      a_raw_q   <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_pend_q <= dz_pend_d;
      a_raw_q   <= a_raw_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Next-state, iteration and write-back logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_pend_d = dz_pend_q;
    a_raw_d   = a_raw_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = '0;
          busy_d    = 1'b1;
          is_div_d  = op_div;
          neg_res_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = op_signed & a[WIDTH-1];
          dz_pend_d = op_div && (b == '0);
          a_raw_d   = a;
          dvs_d     = op_div ? abs_b : abs_a;
          rem_d     = '0;
          acc_d     = {WIDTH'(0), (op_div ? abs_a : abs_b)};
        end
      end

      RUN: begin
        if (flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div_q) begin
            rem_d = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
          end
          if (cnt_q == LAST_STEP) begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!flush) begin
          done_d = 1'b1;
          dz_d   = dz_pend_q;
          if (dz_pend_q) begin
            lo_d = '1;
            hi_d = a_raw_q;
          end else if (is_div_q) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32 plus a WIDTH=8 instance.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  logic        start8, flush8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int n_cmp;
  int n_fail;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
    .busy(busy8), .done(done8), .dz(dz8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op on the 32-bit unit; return edges from accept to done and busy-high cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int edges, output int busy_len);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'b11; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    edges = 0;
    busy_len = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy === 1'b1) busy_len++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
    n_cmp++; if (dz !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b, expected 0", dz); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h_%h, expected 0", hi, lo); end
    n_cmp++; if ({busy8, hi8, lo8} !== 17'h0) begin n_fail++; $display("FAIL reset_w8: got %b %h %h, expected 0", busy8, hi8, lo8); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_multu();
    int e, bl;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bl);
    n_cmp++; if (e != 33) begin n_fail++; $display("FAIL multu_latency: got %0d, expected 33", e); end
    n_cmp++; if (bl != 33) begin n_fail++; $display("FAIL multu_busy_len: got %0d, expected 33", bl); end
    n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h, expected fffffffe", hi); end
    n_cmp++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h, expected 00000001", lo); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_at_done: got %b, expected 0", busy); end
  endtask

  task automatic test_mult_signed();
    int e, bl;
    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, e, bl);
    n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_neg: got %h_%h, expected ffffffff_ffffffeb", hi, lo); end
    @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b, expected 0", done); end
    n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL hilo_hold: got %h_%h, expected ffffffff_ffffffeb", hi, lo); end
  endtask

  task automatic test_div_signed();
    int e, bl;
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, e, bl);
    n_cmp++; if (e != 33) begin n_fail++; $display("FAIL div_latency: got %0d, expected 33", e); end
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h, expected fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h, expected ffffffff", hi); end
  endtask

  task automatic test_div_zero();
    int e, bl;
    run_op(2'b10, 32'h0000_0064, 32'h0000_0000, e, bl);
    n_cmp++; if (e != 33) begin n_fail++; $display("FAIL dz_latency: got %0d, expected 33", e); end
    n_cmp++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b, expected 1", dz); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_lo: got %h, expected ffffffff", lo); end
    n_cmp++; if (hi !== 32'h0000_0064) begin n_fail++; $display("FAIL dz_hi: got %h, expected 00000064", hi); end
    run_op(2'b10, 32'h0000_0064, 32'h0000_0007, e, bl);
    n_cmp++; if (lo !== 32'h0000_000E) begin n_fail++; $display("FAIL divu_lo: got %h, expected 0000000e", lo); end
    n_cmp++; if (hi !== 32'h0000_0002) begin n_fail++; $display("FAIL divu_hi: got %h, expected 00000002", hi); end
    n_cmp++; if (dz !== 1'b0) begin n_fail++; $display("FAIL dz_clear: got %b, expected 0", dz); end
  endtask

  task automatic test_overflow();
    int e, bl;
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, e, bl);
    n_cmp++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL div_ovf: got %h_%h, expected 00000000_80000000", hi, lo); end
    n_cmp++; if (dz !== 1'b0) begin n_fail++; $display("FAIL div_ovf_dz: got %b, expected 0", dz); end
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, e, bl);
    n_cmp++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL mult_min: got %h_%h, expected 40000000_00000000", hi, lo); end
  endtask

  task automatic test_start_held();
    int ndone;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
    @(posedge clk);
    #1;
    a = 32'd9; b = 32'd9;
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    n_cmp++; if (ndone != 1) begin n_fail++; $display("FAIL start_held_dones: got %0d, expected 1", ndone); end
    n_cmp++; if ({hi, lo} !== 64'd30) begin n_fail++; $display("FAIL start_held_result: got %h_%h, expected 0_1e", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int e, bl;
    run_op(2'b00, 32'd6, 32'd7, e, bl);
    n_cmp++; if (lo !== 32'h0000_002A) begin n_fail++; $display("FAIL b2b_first_lo: got %h, expected 0000002a", lo); end
    start = 1'b1; op = 2'b10; a = 32'd50; b = 32'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = 0;
    while (done !== 1'b1 && e < 100) begin
      @(posedge clk);
      #1;
      e++;
    end
    n_cmp++; if (e != 33) begin n_fail++; $display("FAIL b2b_latency: got %0d, expected 33", e); end
    n_cmp++; if ({hi, lo} !== 64'h0000_0002_0000_0006) begin n_fail++; $display("FAIL b2b_result: got %h_%h, expected 00000002_00000006", hi, lo); end
  endtask

  task automatic test_flush();
    int ndone;
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b, expected 0", busy); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    n_cmp++; if (ndone != 0) begin n_fail++; $display("FAIL flush_done: got %0d, expected 0", ndone); end
    n_cmp++; if ({dz, hi, lo} !== {1'b0, 64'h0000_0002_0000_0006}) begin n_fail++; $display("FAIL flush_hold: got %b %h_%h, expected 0 00000002_00000006", dz, hi, lo); end
  endtask

  task automatic test_reset_mid();
    int e, bl;
    run_op(2'b10, 32'd5, 32'd0, e, bl);
    n_cmp++; if (dz !== 1'b1) begin n_fail++; $display("FAIL pre_reset_dz: got %b, expected 1", dz); end
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if ({busy, done, dz} !== 3'b000) begin n_fail++; $display("FAIL reset_mid_flags: got %b, expected 000", {busy, done, dz}); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL reset_mid_hilo: got %h_%h, expected 0", hi, lo); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_width8();
    int e;
    @(negedge clk);
    start8 = 1'b1; op8 = 2'b00; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    e = 0;
    while (done8 !== 1'b1 && e < 100) begin
      @(posedge clk);
      #1;
      e++;
    end
    n_cmp++; if (e != 9) begin n_fail++; $display("FAIL w8_latency: got %0d, expected 9", e); end
    n_cmp++; if ({hi8, lo8} !== 16'hFE01) begin n_fail++; $display("FAIL w8_result: got %h_%h, expected fe_01", hi8, lo8); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_multu();
    test_mult_signed();
    test_div_signed();
    test_div_zero();
    test_overflow();
    test_start_held();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
